// File: rtl/fp_multiply_stream_if.sv
// Stream interface for fp_multiply_stream.
//
// Carries both the operand stream (into the multiplier) and the product stream
// (out of it) on one bundle, with a shared LANES width.
//   dataAIn / dataBIn : packed operands, lane i in bits [32i+31:32i]
//   validIn / readyOut: operand handshake
//   dataOut           : packed products, same lane packing
//   validOut / readyIn: product handshake
//   flagsOut          : per-lane {invalid, overflow, underflow, inexact}, only
//                       when FP_MULT_FLAGS_EN is defined
// Modports: slave is the multiplier side, master is the producer/consumer side.
interface fp_multiply_stream_if #(
  parameter int unsigned LANES = 1
);
  logic [32*LANES-1:0] dataAIn;
  logic [32*LANES-1:0] dataBIn;
  logic                validIn;
  logic                readyOut;
  logic [32*LANES-1:0] dataOut;
  logic                validOut;
  logic                readyIn;
`ifdef FP_MULT_FLAGS_EN
  logic [4*LANES-1:0]  flagsOut;
`endif

  modport slave (
    input  dataAIn,
    input  dataBIn,
    input  validIn,
    input  readyIn,
    output readyOut,
    output dataOut,
`ifdef FP_MULT_FLAGS_EN
    output flagsOut,
`endif
    output validOut
  );

  modport master (
    output dataAIn,
    output dataBIn,
    output validIn,
    output readyIn,
    input  readyOut,
    input  dataOut,
`ifdef FP_MULT_FLAGS_EN
    input  flagsOut,
`endif
    input  validOut
  );
endinterface

// File: rtl/fp_multiply_stream.sv
// Multi-lane pipelined IEEE-754 single-precision multiplier with valid/ready
// flow control.
//
// LANES independent multipliers share one handshake. Three register stages:
//   S1: unpack, flush subnormals to zero, classify, sign and biased exponent sum
//   S2: 24x24 mantissa product
//   S3: normalise, round to nearest even, pack (this is the output register)
// Special values (NaN, inf, zero) are resolved in S1 and carried alongside the
// datapath so that S3 just selects them.
//
// Ports:
//   clkIn : clock, rising edge
//   rstIn : synchronous active-high reset
//   bus   : fp_multiply_stream_if slave modport (operand and product streams)
//
// Optional feature macro: FP_MULT_FLAGS_EN adds flagsOut and the flag
// registers that travel with each stage. dataOut is identical either way.
module fp_multiply_stream #(
  parameter int unsigned LANES = 1
) (
  input logic                 clkIn,
  input logic                 rstIn,
  fp_multiply_stream_if.slave bus
);

  localparam logic [31:0] QNan = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic signed [9:0] exp;
    logic [23:0]       mant_a;
    logic [23:0]       mant_b;
    logic              spec;      // result fully decided by special-value rules
    logic [31:0]       spec_val;
`ifdef FP_MULT_FLAGS_EN
    logic [3:0]        flags;
`endif
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic signed [9:0] exp;
    logic [47:0]       prod;
    logic              spec;
    logic [31:0]       spec_val;
`ifdef FP_MULT_FLAGS_EN
    logic [3:0]        flags;
`endif
  } s2_t;

  typedef struct packed {
    logic [31:0] data;
`ifdef FP_MULT_FLAGS_EN
    logic [3:0]  flags;
`endif
  } s3_t;

  // Classify both operands and form sign/exponent. Subnormals count as zero.
  function automatic s1_t unpack_lane(input logic [31:0] a, input logic [31:0] b);
    s1_t  r;
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;
    a_zero = (a[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_zero = (b[30:23] == 8'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

    r        = '0;
    r.sign   = a[31] ^ b[31];
    r.exp    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    r.mant_a = {1'b1, a[22:0]};
    r.mant_b = {1'b1, b[22:0]};

    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      r.spec     = 1'b1;
      r.spec_val = QNan;
`ifdef FP_MULT_FLAGS_EN
      r.flags    = 4'b1000;
`endif
    end else if (a_inf || b_inf) begin
      r.spec     = 1'b1;
      r.spec_val = {r.sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      r.spec     = 1'b1;
      r.spec_val = {r.sign, 31'd0};
    end
    return r;
  endfunction

  // Normalise, round to nearest even, then range-check the exponent.
  function automatic s3_t finish_lane(input s2_t s);
    s3_t               r;
    logic [23:0]       kept;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [24:0]       rounded;
    logic signed [9:0] exp;
    logic [22:0]       frac;

    r = '0;
    // Both mantissas carry a hidden one, so the product has bit 46 or 47 set.
    if (s.prod[47]) begin
      kept   = s.prod[47:24];
      guard  = s.prod[23];
      sticky = |s.prod[22:0];
      exp    = s.exp + 10'sd1;
    end else begin
      kept   = s.prod[46:23];
      guard  = s.prod[22];
      sticky = |s.prod[21:0];
      exp    = s.exp;
    end

    round_up = guard & (sticky | kept[0]);
    rounded  = {1'b0, kept} + {24'd0, round_up};
    // A carry out leaves 1.000..0 x 2; the fraction field is then all zero.
    if (rounded[24]) begin
      frac = rounded[23:1];
      exp  = exp + 10'sd1;
    end else begin
      frac = rounded[22:0];
    end

    if (s.spec) begin
      r.data  = s.spec_val;
`ifdef FP_MULT_FLAGS_EN
      r.flags = s.flags;
`endif
    end else if (exp >= 10'sd255) begin
      r.data  = {s.sign, 8'hFF, 23'd0};
`ifdef FP_MULT_FLAGS_EN
      r.flags = 4'b0101;
`endif
    end else if (exp <= 10'sd0) begin
      r.data  = {s.sign, 31'd0};
`ifdef FP_MULT_FLAGS_EN
      r.flags = 4'b0011;
`endif
    end else begin
      r.data  = {s.sign, exp[7:0], frac};
`ifdef FP_MULT_FLAGS_EN
      r.flags = {3'b000, guard | sticky};
`endif
    end
    return r;
  endfunction

  logic adv;
  logic s1_valid_q, s2_valid_q, s3_valid_q;

  s1_t s1_d [LANES];
  s1_t s1_q [LANES];
  s2_t s2_d [LANES];
  s2_t s2_q [LANES];
  s3_t s3_res [LANES];

  logic [32*LANES-1:0] s3_data_d, s3_data_q;
`ifdef FP_MULT_FLAGS_EN
  logic [4*LANES-1:0]  s3_flags_d, s3_flags_q;
`endif

  // Whole pipeline moves together; no skid buffer, so readyOut follows readyIn.
  assign adv = !s3_valid_q || bus.readyIn;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      s1_d[i] = unpack_lane(bus.dataAIn[32*i +: 32], bus.dataBIn[32*i +: 32]);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      s2_d[i]          = '0;
      s2_d[i].sign     = s1_q[i].sign;
      s2_d[i].exp      = s1_q[i].exp;
      s2_d[i].prod     = {24'd0, s1_q[i].mant_a} * {24'd0, s1_q[i].mant_b};
      s2_d[i].spec     = s1_q[i].spec;
      s2_d[i].spec_val = s1_q[i].spec_val;
`ifdef FP_MULT_FLAGS_EN
      s2_d[i].flags    = s1_q[i].flags;
`endif
    end
  end

  always_comb begin
    s3_data_d  = '0;
`ifdef FP_MULT_FLAGS_EN
    s3_flags_d = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      s3_res[i]              = finish_lane(s2_q[i]);
      s3_data_d[32*i +: 32]  = s3_res[i].data;
`ifdef FP_MULT_FLAGS_EN
      s3_flags_d[4*i +: 4]   = s3_res[i].flags;
`endif
    end
  end

  // Valid bits and the visible output register.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
`ifdef FP_MULT_FLAGS_EN
      s3_flags_q <= '0;
`endif
    end else if (adv) begin
      s1_valid_q <= bus.validIn;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      // Bubbles leave the last product on the bus rather than garbage.
      if (s2_valid_q) begin
        s3_data_q  <= s3_data_d;
`ifdef FP_MULT_FLAGS_EN
        s3_flags_q <= s3_flags_d;
`endif
      end
    end
  end

  // Internal datapath registers; contents only matter where the valid bit is set.
  always_ff @(posedge clkIn) begin
    if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign bus.readyOut = adv;
  assign bus.validOut = s3_valid_q;
  assign bus.dataOut  = s3_data_q;
`ifdef FP_MULT_FLAGS_EN
  assign bus.flagsOut = s3_flags_q;
`endif

endmodule

// File: tb/tb_fp_multiply_stream.sv
// Self-checking bench for fp_multiply_stream: table vectors and latency on a
// 1-lane instance, backpressure and reset sequences, per-lane isolation and a
// randomised stream on a 4-lane instance checked against a reference model.
module tb_fp_multiply_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_multiply_stream_if #(.LANES(1)) b1 ();
  fp_multiply_stream_if #(.LANES(4)) b4 ();

  fp_multiply_stream #(.LANES(1)) u_d1 (.clkIn(clk), .rstIn(rst), .bus(b1));
  fp_multiply_stream #(.LANES(4)) u_d4 (.clkIn(clk), .rstIn(rst), .bus(b4));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [127:0] y;
    logic [15:0]  f;
  } exp4_t;

  localparam int NV = 12;
  localparam int NR = 300;

  vec_t  vecs [NV];
  exp4_t q4 [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer product, rounded by remainder versus half-ulp.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic              za, ia, na, zb, ib, nb;
    longint unsigned   ma, mb, p, q, r, half;
    int                e, sh;
    logic              inx;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 0);
    zb = (b[30:23] == 0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (na || nb || (ia && zb) || (za && ib)) return {4'b1000, 32'h7FC00000};
    if (ia || ib) return {4'b0000, s, 8'hFF, 23'd0};
    if (za || zb) return {4'b0000, s, 31'd0};
    ma = 64'(a[22:0]) + (64'd1 << 23);
    mb = 64'(b[22:0]) + (64'd1 << 23);
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    half = 64'd1 << (sh - 1);
    q    = p >> sh;
    r    = p - (q << sh);
    inx  = (r != 0);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0011, s, 31'd0};
    return {3'b000, inx, s, 8'(e), 23'(q)};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    int unsigned k;
    k = $urandom_range(0, 15);
    s = 1'($urandom);
    f = 23'($urandom);
    case (k)
      0:       begin e = 8'd0; f = 23'd0; end
      1:       e = 8'd0;
      2:       begin e = 8'hFF; f = 23'd0; end
      3:       begin e = 8'hFF; f[0] = 1'b1; end
      4, 5:    e = 8'($urandom);
      6:       begin e = 8'($urandom_range(100, 154)); f = 23'h7FFFFF ^ 23'($urandom_range(0, 7)); end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  task automatic wait_valid1(output int lat);
    lat = 1;
    while (!b1.validOut && lat < 10) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_valid4(output int lat);
    lat = 1;
    while (!b4.validOut && lat < 10) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
    vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    vecs[3]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};
    vecs[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
    vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[10] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};  // tie, round up to even
    vecs[11] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};  // tie, stay even

    b1.dataAIn = '0; b1.dataBIn = '0; b1.validIn = 1'b0; b1.readyIn = 1'b1;
    b4.dataAIn = '0; b4.dataBIn = '0; b4.validIn = 1'b0; b4.readyIn = 1'b1;

    // Reset state
    step();
    step();
    check("rst_valid_out", 32'(b1.validOut), 32'd0);
    check("rst_ready_out", 32'(b1.readyOut), 32'd1);
    check("rst_data_out", b1.dataOut, 32'd0);
    check("rst4_valid_out", 32'(b4.validOut), 32'd0);
`ifdef FP_MULT_FLAGS_EN
    check("rst_flags_out", 32'(b1.flagsOut), 32'd0);
`endif
    rst = 1'b0;
    step();

    // Table vectors, one at a time, with latency
    for (int i = 0; i < NV; i++) begin
      b1.dataAIn = vecs[i].a;
      b1.dataBIn = vecs[i].b;
      b1.validIn = 1'b1;
      b1.readyIn = 1'b1;
      step();
      b1.validIn = 1'b0;
      wait_valid1(lat);
      check("vec_latency", lat, 32'd3);
      check("vec_data", b1.dataOut, vecs[i].y);
`ifdef FP_MULT_FLAGS_EN
      check("vec_flags", 32'(b1.flagsOut), 32'(vecs[i].f));
`endif
      step();
    end

    // Four lanes in one beat; second beat has a NaN in lane 2
    for (int beat = 0; beat < 2; beat++) begin
      int sel [4];
      if (beat == 0) sel = '{0, 2, 4, 6};
      else sel = '{1, 3, 8, 7};
      for (int l = 0; l < 4; l++) begin
        b4.dataAIn[32*l +: 32] = vecs[sel[l]].a;
        b4.dataBIn[32*l +: 32] = vecs[sel[l]].b;
      end
      b4.validIn = 1'b1;
      b4.readyIn = 1'b1;
      step();
      b4.validIn = 1'b0;
      wait_valid4(lat);
      check("lanes_latency", lat, 32'd3);
      for (int l = 0; l < 4; l++) begin
        check("lanes_data", b4.dataOut[32*l +: 32], vecs[sel[l]].y);
`ifdef FP_MULT_FLAGS_EN
        check("lanes_flags", 32'(b4.flagsOut[4*l +: 4]), 32'(vecs[sel[l]].f));
`endif
      end
      step();
    end

    // Backpressure on one lane: readyIn 1,0,0,1,...
    begin
      int sent = 0, got = 0, cyc = 0;
      logic xfer, outh, stall;
      logic [31:0] held;
      b1.validIn = 1'b0;
      while (got < 8 && cyc < 200) begin
        b1.readyIn = (cyc % 4 == 0) || (cyc % 4 == 3);
        if (sent < 8) begin
          b1.dataAIn = vecs[sent].a;
          b1.dataBIn = vecs[sent].b;
          b1.validIn = 1'b1;
        end else begin
          b1.validIn = 1'b0;
        end
        #1;
        xfer  = b1.validIn && b1.readyOut;
        outh  = b1.validOut && b1.readyIn;
        stall = b1.validOut && !b1.readyIn;
        held  = b1.dataOut;
        if (stall) check("bp_ready_low", 32'(b1.readyOut), 32'd0);
        if (outh) begin
          check("bp_data", b1.dataOut, vecs[got].y);
          got++;
        end
        step();
        if (xfer) sent++;
        if (stall) begin
          check("bp_hold_valid", 32'(b1.validOut), 32'd1);
          check("bp_hold_data", b1.dataOut, held);
        end
        cyc++;
      end
      b1.validIn = 1'b0;
      check("bp_count", got, 32'd8);
      b1.readyIn = 1'b1;
      step();
      check("bp_no_extra", 32'(b1.validOut), 32'd0);
    end

    // Reset with three operands in flight, operands presented during reset
    b1.readyIn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b1.dataAIn = vecs[k].a;
      b1.dataBIn = vecs[k].b;
      b1.validIn = 1'b1;
      step();
    end
    rst = 1'b1;
    b1.dataAIn = vecs[3].a;
    b1.dataBIn = vecs[3].b;
    step();
    check("midrst_valid", 32'(b1.validOut), 32'd0);
    check("midrst_ready", 32'(b1.readyOut), 32'd1);
    check("midrst_data", b1.dataOut, 32'd0);
    rst = 1'b0;
    b1.validIn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("postrst_valid", 32'(b1.validOut), 32'd0);
    end
    b1.dataAIn = vecs[4].a;
    b1.dataBIn = vecs[4].b;
    b1.validIn = 1'b1;
    step();
    b1.validIn = 1'b0;
    wait_valid1(lat);
    check("postrst_latency", lat, 32'd3);
    check("postrst_data", b1.dataOut, vecs[4].y);
    step();

    // Randomised four-lane stream with random backpressure
    begin
      int sent = 0, got = 0, cyc = 0;
      logic xfer, outh, stall;
      logic [127:0] held;
      exp4_t e, g;
      logic [35:0] r;
      b4.validIn = 1'b0;
      while (got < NR && cyc < 20 * NR) begin
        b4.readyIn = ($urandom_range(0, 3) != 0);
        if (!b4.validIn && sent < NR && $urandom_range(0, 4) != 0) begin
          for (int l = 0; l < 4; l++) begin
            b4.dataAIn[32*l +: 32] = rand_op();
            b4.dataBIn[32*l +: 32] = rand_op();
          end
          b4.validIn = 1'b1;
        end
        #1;
        xfer  = b4.validIn && b4.readyOut;
        outh  = b4.validOut && b4.readyIn;
        stall = b4.validOut && !b4.readyIn;
        held  = b4.dataOut;
        if (stall) check("rand_ready_low", 32'(b4.readyOut), 32'd0);
        if (outh) begin
          if (q4.size() == 0) begin
            check("rand_unexpected", 32'd1, 32'd0);
          end else begin
            g = q4.pop_front();
            for (int l = 0; l < 4; l++) begin
              check("rand_data", b4.dataOut[32*l +: 32], g.y[32*l +: 32]);
`ifdef FP_MULT_FLAGS_EN
              check("rand_flags", 32'(b4.flagsOut[4*l +: 4]), 32'(g.f[4*l +: 4]));
`endif
            end
          end
          got++;
        end
        if (xfer) begin
          for (int l = 0; l < 4; l++) begin
            r = ref_mul(b4.dataAIn[32*l +: 32], b4.dataBIn[32*l +: 32]);
            e.y[32*l +: 32] = r[31:0];
            e.f[4*l +: 4]   = r[35:32];
          end
          q4.push_back(e);
        end
        step();
        if (xfer) begin
          sent++;
          b4.validIn = 1'b0;
        end
        if (stall) check("rand_hold_data", b4.dataOut[31:0] ^ held[31:0] ^ b4.dataOut[127:96] ^ held[127:96], 32'd0);
        cyc++;
      end
      check("rand_count", got, NR);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
